// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit: FSM sequencing FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP
// with a MemReady wait counter that escalates to a sticky ERROR state on timeout.
module multicycle_controller #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter bit ENABLE_MUL  = 1'b1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [5:0]         OpCode,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IRWrite,
  output logic               IorD,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               AluSrcA,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               SignExt,
  output logic               Branch,
  output logic               BranchNe,
  output logic               Jump,
  output logic               Retire,
  output logic               IllegalOp,
  output logic               Error,
  output logic [1:0]         AluSrcB,
  output logic [ALUOP_W-1:0] AluOp,
  output logic [2:0]         State
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_BRANCH = 3'd5, S_JUMP = 3'd6, S_ERROR = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R = 4'd0, C_MUL = 4'd1, C_SEH = 4'd2, C_ADDIU = 4'd3, C_ADDI = 4'd4,
    C_ANDI = 4'd5, C_ORI = 4'd6, C_XORI = 4'd7, C_SLTI = 4'd8, C_SLTIU = 4'd9,
    C_LW = 4'd10, C_SW = 4'd11, C_BEQ = 4'd12, C_BNE = 4'd13, C_J = 4'd14, C_ILL = 4'd15
  } cls_t;

  function automatic cls_t decode_op(input logic [5:0] op);
    case (op)
      6'b000000: decode_op = C_R;
      6'b011100: decode_op = ENABLE_MUL ? C_MUL : C_ILL;
      6'b011111: decode_op = C_SEH;
      6'b001001: decode_op = C_ADDIU;
      6'b001000: decode_op = C_ADDI;
      6'b001100: decode_op = C_ANDI;
      6'b001101: decode_op = C_ORI;
      6'b001110: decode_op = C_XORI;
      6'b001010: decode_op = C_SLTI;
      6'b001011: decode_op = C_SLTIU;
      6'b100011: decode_op = C_LW;
      6'b101011: decode_op = C_SW;
      6'b000100: decode_op = C_BEQ;
      6'b000101: decode_op = C_BNE;
      6'b000010: decode_op = C_J;
      default:   decode_op = C_ILL;
    endcase
  endfunction

  state_t     state_q, state_d;
  cls_t       cls_q, cls_d;
  cls_t       dec_cls_s;
  logic [7:0] cnt_q, cnt_d;
  logic       active_q;
  logic       timeout_s;
  logic [3:0] alu_op4_s;

  assign dec_cls_s = decode_op(OpCode);
  // The n-th consecutive MemReady=0 cycle counts as waited cycle n.
  assign timeout_s = !MemReady && (cnt_q == 8'(MEM_TIMEOUT - 1));
  assign State     = state_q;

  // State, class, wait counter and run-enable registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_FETCH;
      cls_q    <= C_R;
      cnt_q    <= 8'd0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      cnt_q    <= cnt_d;
      active_q <= 1'b1;
    end
  end

  // Next-state, class capture and wait-counter update.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    if (active_q) begin
      case (state_q)
        S_FETCH: begin
          if (MemReady)       state_d = S_DECODE;
          else if (timeout_s) state_d = S_ERROR;
          else                state_d = S_FETCH;
        end
        S_DECODE: begin
          cls_d = dec_cls_s;
          case (dec_cls_s)
            C_BEQ, C_BNE: state_d = S_BRANCH;
            C_J:          state_d = S_JUMP;
            C_ILL:        state_d = S_ERROR;
            default:      state_d = S_EXEC;
          endcase
        end
        S_EXEC: state_d = (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_WB;
        S_MEM: begin
          if (MemReady)       state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
          else if (timeout_s) state_d = S_ERROR;
          else                state_d = S_MEM;
        end
        S_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_ERROR;
      endcase
    end else begin
      state_d = state_q;
    end
    if (state_d != state_q)
      cnt_d = 8'd0;
    else if (active_q && (state_q == S_FETCH || state_q == S_MEM) && !MemReady)
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = cnt_q;
  end

  // Control-strobe decode from registered state and class.
  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IRWrite = 1'b0; IorD = 1'b0;
    RegDst = 1'b0; RegWrite = 1'b0; AluSrcA = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; MemToReg = 1'b0; SignExt = 1'b0; Branch = 1'b0;
    BranchNe = 1'b0; Jump = 1'b0; Retire = 1'b0; IllegalOp = 1'b0;
    Error = 1'b0; AluSrcB = 2'b00; alu_op4_s = 4'b0000;
    if (active_q) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1; AluSrcB = 2'b01; alu_op4_s = 4'b0010;
          IRWrite = MemReady; PCWrite = MemReady;
        end
        S_DECODE: begin
          AluSrcB = 2'b11; alu_op4_s = 4'b0010;
          IllegalOp = (dec_cls_s == C_ILL);
        end
        S_EXEC: begin
          AluSrcA = 1'b1;
          case (cls_q)
            C_R:     begin alu_op4_s = 4'b0000; SignExt = 1'b1; AluSrcB = 2'b00; end
            C_MUL:   begin alu_op4_s = 4'b1100; SignExt = 1'b1; AluSrcB = 2'b00; end
            C_SEH:   begin alu_op4_s = 4'b0000; SignExt = 1'b0; AluSrcB = 2'b00; end
            C_ADDIU: begin alu_op4_s = 4'b0111; SignExt = 1'b0; AluSrcB = 2'b10; end
            C_ADDI:  begin alu_op4_s = 4'b0001; SignExt = 1'b1; AluSrcB = 2'b10; end
            C_ANDI:  begin alu_op4_s = 4'b0100; SignExt = 1'b0; AluSrcB = 2'b10; end
            C_ORI:   begin alu_op4_s = 4'b0011; SignExt = 1'b0; AluSrcB = 2'b10; end
            C_XORI:  begin alu_op4_s = 4'b0101; SignExt = 1'b0; AluSrcB = 2'b10; end
            C_SLTI:  begin alu_op4_s = 4'b1010; SignExt = 1'b1; AluSrcB = 2'b10; end
            C_SLTIU: begin alu_op4_s = 4'b1011; SignExt = 1'b1; AluSrcB = 2'b10; end
            default: begin alu_op4_s = 4'b0010; SignExt = 1'b1; AluSrcB = 2'b10; end
          endcase
        end
        S_MEM: begin
          IorD     = 1'b1;
          MemRead  = (cls_q == C_LW);
          MemWrite = (cls_q == C_SW);
          Retire   = MemReady && (cls_q == C_SW);
        end
        S_WB: begin
          RegWrite = 1'b1; Retire = 1'b1;
          RegDst   = !(cls_q == C_R || cls_q == C_MUL);
          MemToReg = (cls_q == C_LW);
        end
        S_BRANCH: begin
          AluSrcA = 1'b1; AluSrcB = 2'b00; alu_op4_s = 4'b0110; PCWriteCond = 1'b1;
          Branch = (cls_q == C_BEQ); BranchNe = (cls_q == C_BNE); Retire = 1'b1;
        end
        S_JUMP: begin
          PCWrite = 1'b1; Jump = 1'b1; Retire = 1'b1;
        end
        S_ERROR: Error = 1'b1;
        default: Error = 1'b1;
      endcase
    end else begin
      alu_op4_s = 4'b0000;
    end
    AluOp = ALUOP_W'(alu_op4_s);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; a second instance with
// ENABLE_MUL=0 shares the stimulus to check mul decoding.
module tb_multicycle_controller;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [5:0] OpCode;
  logic       MemReady;

  logic PCWrite, PCWriteCond, IRWrite, IorD, RegDst, RegWrite, AluSrcA, MemRead;
  logic MemWrite, MemToReg, SignExt, Branch, BranchNe, Jump, Retire, IllegalOp, Error;
  logic [1:0] AluSrcB;
  logic [3:0] AluOp;
  logic [2:0] State;

  logic n_PCWrite, n_PCWriteCond, n_IRWrite, n_IorD, n_RegDst, n_RegWrite, n_AluSrcA, n_MemRead;
  logic n_MemWrite, n_MemToReg, n_SignExt, n_Branch, n_BranchNe, n_Jump, n_Retire, n_IllegalOp, n_Error;
  logic [1:0] n_AluSrcB;
  logic [3:0] n_AluOp;
  logic [2:0] n_State;

  int n_tests = 0;
  int n_fail  = 0;

  int         exp_st  [23] = '{0,1,2,4, 0,1,2,4, 0,1,2,3,4, 0,1,2,3, 0,1,5, 0,1,6};
  logic [5:0] seq_ops [6]  = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
  logic [3:0] exp_alu [4]  = '{4'b0000, 4'b0001, 4'b0010, 4'b0010};

  multicycle_controller #(.ALUOP_W(4), .MEM_TIMEOUT(15), .ENABLE_MUL(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .OpCode(OpCode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite), .IorD(IorD),
    .RegDst(RegDst), .RegWrite(RegWrite), .AluSrcA(AluSrcA), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .SignExt(SignExt), .Branch(Branch),
    .BranchNe(BranchNe), .Jump(Jump), .Retire(Retire), .IllegalOp(IllegalOp),
    .Error(Error), .AluSrcB(AluSrcB), .AluOp(AluOp), .State(State)
  );

  multicycle_controller #(.ALUOP_W(4), .MEM_TIMEOUT(15), .ENABLE_MUL(1'b0)) dut_nm (
    .Clk(Clk), .Rst(Rst), .OpCode(OpCode), .MemReady(MemReady),
    .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .IRWrite(n_IRWrite), .IorD(n_IorD),
    .RegDst(n_RegDst), .RegWrite(n_RegWrite), .AluSrcA(n_AluSrcA), .MemRead(n_MemRead),
    .MemWrite(n_MemWrite), .MemToReg(n_MemToReg), .SignExt(n_SignExt), .Branch(n_Branch),
    .BranchNe(n_BranchNe), .Jump(n_Jump), .Retire(n_Retire), .IllegalOp(n_IllegalOp),
    .Error(n_Error), .AluSrcB(n_AluSrcB), .AluOp(n_AluOp), .State(n_State)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds reset for two edges, releases it between edges, then steps into cycle 1.
  task automatic do_reset();
    Rst = 1'b0;
    repeat (2) tick();
    Rst = 1'b1;
    #1;
    check("post_release_idle_memread", MemRead, 0);
    tick();
  endtask

  initial begin
    int oi;
    int ei;
    Rst = 1'b0; OpCode = 6'b000000; MemReady = 1'b1;

    // Reset state: every output low, State=FETCH.
    repeat (2) tick();
    check("rst_state", State, 0);
    check("rst_memread", MemRead, 0);
    check("rst_error", Error, 0);
    check("rst_aluop", AluOp, 0);
    check("rst_alusrcb", AluSrcB, 0);
    Rst = 1'b1;
    #1;
    check("post_release_idle_memread", MemRead, 0);
    tick();
    check("first_fetch_memread", MemRead, 1);

    // Instruction stream with MemReady tied high.
    oi = 0; ei = 0;
    for (int c = 1; c <= 23; c++) begin
      if (exp_st[c-1] == 0) begin
        OpCode = seq_ops[oi];
        oi++;
        check($sformatf("seq_memread_c%0d", c), MemRead, 1);
      end
      check($sformatf("seq_state_c%0d", c), State, exp_st[c-1]);
      check($sformatf("seq_retire_c%0d", c), Retire,
            (c == 4 || c == 8 || c == 13 || c == 17 || c == 20 || c == 23) ? 1 : 0);
      if (exp_st[c-1] == 2) begin
        check($sformatf("seq_aluop_c%0d", c), AluOp, exp_alu[ei]);
        ei++;
      end
      if (c == 4)  check("seq_r_regdst", RegDst, 0);
      if (c == 8)  check("seq_addi_regdst", RegDst, 1);
      if (c == 12) check("seq_sw_memwrite", MemWrite, 0);
      if (c == 17) check("seq_sw_memwrite", MemWrite, 1);
      if (c == 20) check("seq_beq_branch", Branch, 1);
      if (c == 23) check("seq_j_jump", Jump, 1);
      tick();
    end
    check("seq_back_to_fetch", State, 0);

    // Illegal opcode: one-cycle IllegalOp then sticky ERROR until reset.
    OpCode = 6'b010000;
    do_reset();
    check("ill_c1_state", State, 0);
    tick();
    check("ill_decode_state", State, 1);
    check("ill_pulse", IllegalOp, 1);
    tick();
    check("ill_err_state", State, 7);
    check("ill_pulse_gone", IllegalOp, 0);
    for (int k = 0; k < 4; k++) begin
      check("ill_error_held", Error, 1);
      check("ill_no_regwrite", RegWrite, 0);
      check("ill_no_pcwrite", PCWrite, 0);
      tick();
    end
    check("ill_still_err", State, 7);
    Rst = 1'b0;
    #1;
    check("ill_rst_error", Error, 0);
    check("ill_rst_state", State, 0);

    // Fetch timeout: 15 MemReady-low cycles end in ERROR.
    MemReady = 1'b0; OpCode = 6'b000000;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      check($sformatf("to_wait_state_c%0d", k), State, 0);
      tick();
    end
    check("to_error_state", State, 7);
    check("to_error_flag", Error, 1);

    // MemReady arriving on the 15th cycle wins over the timeout.
    MemReady = 1'b0;
    do_reset();
    repeat (14) tick();
    MemReady = 1'b1;
    #1;
    check("to_late_irwrite", IRWrite, 1);
    check("to_late_pcwrite", PCWrite, 1);
    tick();
    check("to_late_decode", State, 1);

    // lw with MemReady held low for three MEM cycles.
    MemReady = 1'b1; OpCode = 6'b100011;
    do_reset();
    tick(); tick();
    check("lw_exec", State, 2);
    MemReady = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) MemReady = 1'b1;
      #1;
      check($sformatf("lw_mem_state_%0d", k), State, 3);
      check($sformatf("lw_memread_%0d", k), MemRead, 1);
      check($sformatf("lw_iord_%0d", k), IorD, 1);
      check($sformatf("lw_no_regwrite_%0d", k), RegWrite, 0);
    end
    tick();
    check("lw_wb_state", State, 4);
    check("lw_regwrite", RegWrite, 1);
    check("lw_memtoreg", MemToReg, 1);
    check("lw_retire", Retire, 1);

    // mul: legal with ENABLE_MUL=1, illegal with ENABLE_MUL=0.
    MemReady = 1'b1; OpCode = 6'b011100;
    do_reset();
    tick();
    check("mul_en_no_illegal", IllegalOp, 0);
    check("mul_dis_illegal", n_IllegalOp, 1);
    tick();
    check("mul_en_exec", State, 2);
    check("mul_en_aluop", AluOp, 4'b1100);
    check("mul_dis_error", n_State, 7);
    check("mul_dis_errflag", n_Error, 1);
    tick();
    check("mul_en_wb", State, 4);
    check("mul_en_regwrite", RegWrite, 1);
    check("mul_en_regdst", RegDst, 0);

    // Reset asserted while sw is stalled in MEM.
    MemReady = 1'b1; OpCode = 6'b101011;
    do_reset();
    tick(); tick();
    MemReady = 1'b0;
    tick();
    check("sw_mem_state", State, 3);
    check("sw_memwrite", MemWrite, 1);
    #2;
    Rst = 1'b0;
    #1;
    check("sw_abort_memwrite", MemWrite, 0);
    check("sw_abort_state", State, 0);
    check("sw_abort_regwrite", RegWrite, 0);
    check("sw_abort_pcwrite", PCWrite, 0);
    tick();
    Rst = 1'b1; MemReady = 1'b1;
    #1;
    check("sw_release_memread_low", MemRead, 0);
    tick();
    check("sw_release_memread", MemRead, 1);
    check("sw_release_state", State, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
